// File: rtl/s27_state_seq.sv
`default_nettype none
// ============================================================================
// Module      : s27_state_seq
// Description : Sequential stage around the s27 combinational core: state
//               flops, valid/ready vector handshake, scan chain, step counter.
// Revision    : 1.0 - initial release
// ============================================================================
module s27_state_seq #(
    parameter logic [2:0] RESET_STATE = 3'b000,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_vec,
    output logic [3:0]       pi_o,
    output logic [2:0]       ps_o,
    input  logic             g17_i,
    input  logic             ns5_i,
    input  logic             ns6_i,
    input  logic             ns7_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_g17,
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
    output logic [CNT_W-1:0] step_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2,
        ST_SCAN = 2'd3
    } fsm_t;

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fsm_t             fsm_q,       fsm_d;
    logic [2:0]       state_q,     state_d;      // {G7,G6,G5}
    logic [3:0]       pi_q,        pi_d;         // {G3,G2,G1,G0}
    logic             out_valid_q, out_valid_d;
    logic             out_g17_q,   out_g17_d;
    logic [CNT_W-1:0] step_cnt_q,  step_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            state_q     <= RESET_STATE;
            pi_q        <= 4'b0000;
            out_valid_q <= 1'b0;
            out_g17_q   <= 1'b0;
            step_cnt_q  <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            pi_q        <= pi_d;
            out_valid_q <= out_valid_d;
            out_g17_q   <= out_g17_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        pi_d        = pi_q;
        out_valid_d = out_valid_q;
        out_g17_d   = out_g17_q;
        step_cnt_d  = step_cnt_q;
        in_ready    = 1'b0;

        case (fsm_q)
            ST_IDLE: begin
                // scan request takes priority over a same-cycle vector
                in_ready = !scan_en;
                if (scan_en) begin
                    fsm_d = ST_SCAN;
                end else if (in_valid) begin
                    pi_d  = in_vec;
                    fsm_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                state_d     = {ns7_i, ns6_i, ns5_i};
                out_g17_d   = g17_i;
                out_valid_d = 1'b1;
                if (step_cnt_q != {CNT_W{1'b1}}) begin
                    step_cnt_d = step_cnt_q + C_CNT_ONE;
                end
                fsm_d = ST_HOLD;
            end
            ST_HOLD: begin
                // scan_en deliberately ignored until the handshake completes
                in_ready = out_ready;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        pi_d  = in_vec;
                        fsm_d = ST_EVAL;
                    end else begin
                        fsm_d = ST_IDLE;
                    end
                end
            end
            ST_SCAN: begin
                if (scan_en) begin
                    state_d = {state_q[1:0], scan_in};
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    assign pi_o      = pi_q;
    assign ps_o      = state_q;
    assign out_valid = out_valid_q;
    assign out_g17   = out_g17_q;
    assign scan_out  = state_q[2];
    assign step_cnt  = step_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_s27_state_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_s27_state_seq
// Description : Scoreboard bench for s27_state_seq with a golden s27 core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s27_state_seq;

    // returns {G17, nextG7, nextG6, nextG5}
    function automatic logic [3:0] s27(input logic [3:0] pi, input logic [2:0] st);
        logic g0, g1, g2, g3, g5, g6, g7;
        logic g8, g9, g10, g11, g12, g13, g14, g15, g16, g17;
        {g3, g2, g1, g0} = pi;
        {g7, g6, g5}     = st;
        g14 = ~g0;
        g8  = g14 & g6;
        g12 = ~(g1 | g7);
        g15 = g12 | g8;
        g16 = g3 | g8;
        g9  = ~(g16 & g15);
        g11 = ~(g5 | g9);
        g10 = ~(g14 | g11);
        g13 = ~(g2 | g12);
        g17 = ~g11;
        return {g17, g13, g11, g10};
    endfunction

    typedef struct {
        logic        g17;
        logic [2:0]  st;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_g17;
    logic [3:0]  in_vec, pi_o;
    logic [2:0]  ps_o;
    logic        g17_i, ns5_i, ns6_i, ns7_i;
    logic        scan_en, scan_in, scan_out;
    logic [15:0] step_cnt;
    logic [3:0]  env_r;

    logic        sat_in_valid, sat_in_ready, sat_out_valid, sat_out_g17, sat_scan_out;
    logic [3:0]  sat_pi;
    logic [2:0]  sat_ps;
    logic [1:0]  sat_cnt;

    exp_t        exp_q[$];
    logic [2:0]  m_state;
    logic [15:0] m_cnt;
    int          acc_cnt;
    int          total = 0;
    int          bad   = 0;
    logic [3:0]  vtab [8];
    logic [2:0]  st_save;

    always #5 clk = ~clk;

    assign env_r = s27(pi_o, ps_o);
    assign g17_i = env_r[3];
    assign ns7_i = env_r[2];
    assign ns6_i = env_r[1];
    assign ns5_i = env_r[0];

    s27_state_seq #(.RESET_STATE(3'b000), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .pi_o(pi_o), .ps_o(ps_o),
        .g17_i(g17_i), .ns5_i(ns5_i), .ns6_i(ns6_i), .ns7_i(ns7_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_g17(out_g17),
        .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
        .step_cnt(step_cnt)
    );

    s27_state_seq #(.RESET_STATE(3'b000), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sat_in_valid), .in_ready(sat_in_ready), .in_vec(4'h3),
        .pi_o(sat_pi), .ps_o(sat_ps),
        .g17_i(1'b0), .ns5_i(1'b0), .ns6_i(1'b0), .ns7_i(1'b0),
        .out_valid(sat_out_valid), .out_ready(1'b1), .out_g17(sat_out_g17),
        .scan_en(1'b0), .scan_in(1'b0), .scan_out(sat_scan_out),
        .step_cnt(sat_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // one cycle: score output handshake, model input handshake, advance clock
    task automatic tick();
        exp_t       e;
        logic [3:0] r;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_g17", {31'd0, out_g17}, {31'd0, e.g17});
                check_eq("state",   {29'd0, ps_o},    {29'd0, e.st});
                check_eq("step_cnt", {16'd0, step_cnt}, {16'd0, e.cnt});
            end
        end
        if (in_valid && in_ready) begin
            r = s27(in_vec, m_state);
            m_state = r[2:0];
            if (m_cnt != 16'hFFFF) m_cnt++;
            e.g17 = r[3];
            e.st  = r[2:0];
            e.cnt = m_cnt;
            exp_q.push_back(e);
            acc_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = 3'b000;
        m_cnt   = 16'd0;
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vtab[0] = 4'h0; vtab[1] = 4'h1; vtab[2] = 4'hF; vtab[3] = 4'h6;
        vtab[4] = 4'h9; vtab[5] = 4'h2; vtab[6] = 4'hC; vtab[7] = 4'h7;
        rst_n = 1'b0; in_valid = 1'b0; in_vec = 4'h0; out_ready = 1'b0;
        scan_en = 1'b0; scan_in = 1'b0; sat_in_valid = 1'b0; acc_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        check_eq("rst_pi",        {28'd0, pi_o},      32'd0);
        check_eq("rst_ps",        {29'd0, ps_o},      32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_g17",   {31'd0, out_g17},   32'd0);
        check_eq("rst_step_cnt",  {16'd0, step_cnt},  32'd0);

        // first vector, then stall in HOLD
        in_vec = 4'h0; in_valid = 1'b1;
        #1 check_eq("idle_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check_eq("eval_ps",        {29'd0, ps_o},      32'd0);
        check_eq("eval_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("eval_in_ready",  {31'd0, in_ready},  32'd0);
        tick();
        check_eq("lat_out_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1; in_vec = 4'h5;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("hold_valid",    {31'd0, out_valid}, 32'd1);
            check_eq("hold_g17",      {31'd0, out_g17},   {31'd0, exp_q[0].g17});
            check_eq("hold_state",    {29'd0, ps_o},      {29'd0, exp_q[0].st});
            check_eq("hold_in_ready", {31'd0, in_ready},  32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1 check_eq("release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check_eq("back_to_idle_valid", {31'd0, out_valid}, 32'd0);

        // streaming throughput
        pulse_reset();
        acc_cnt  = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_vec = vtab[acc_cnt % 8];
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check_eq("stream_accepts",  acc_cnt,            32'd8);
        check_eq("stream_step_cnt", {16'd0, step_cnt},  32'd8);
        check_eq("stream_drained",  exp_q.size(),       32'd0);

        // scan shift 1,0,1
        scan_en = 1'b1;
        tick();
        check_eq("scan_in_ready",  {31'd0, in_ready},  32'd0);
        check_eq("scan_out_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            scan_in = (i == 1) ? 1'b0 : 1'b1;
            m_state = {m_state[1:0], scan_in};
            tick();
        end
        check_eq("scan_ps",  {29'd0, ps_o},     32'd5);
        check_eq("scan_out", {31'd0, scan_out}, 32'd1);
        scan_en = 1'b0;
        tick();
        check_eq("scan_exit_ps",  {29'd0, ps_o},     32'd5);
        check_eq("scan_step_cnt", {16'd0, step_cnt}, 32'd8);
        in_valid = 1'b1; in_vec = 4'h3;
        tick();
        in_valid = 1'b0;
        check_eq("scan_eval_ps", {29'd0, ps_o}, 32'd5);
        tick();
        tick();

        // scan_en and in_valid together in IDLE
        acc_cnt  = 0;
        in_valid = 1'b1; in_vec = 4'hA; scan_en = 1'b1;
        #1 check_eq("prio_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check_eq("prio_no_accept", acc_cnt, 32'd0);
        check_eq("prio_scan_ready", {31'd0, in_ready}, 32'd0);
        scan_en = 1'b0; in_valid = 1'b0;
        tick();
        check_eq("prio_ps", {29'd0, ps_o}, {29'd0, m_state});

        // scan_en raised during HOLD is deferred
        out_ready = 1'b0; in_valid = 1'b1; in_vec = 4'hA;
        tick();
        in_valid = 1'b0;
        tick();
        scan_en = 1'b1; scan_in = 1'b1;
        st_save = m_state;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("defer_valid",    {31'd0, out_valid}, 32'd1);
            check_eq("defer_in_ready", {31'd0, in_ready},  32'd0);
            check_eq("defer_ps",       {29'd0, ps_o},      {29'd0, st_save});
            tick();
        end
        out_ready = 1'b1;
        tick();
        check_eq("defer_idle_valid", {31'd0, out_valid}, 32'd0);
        check_eq("defer_idle_ps",    {29'd0, ps_o},      {29'd0, st_save});
        tick();
        m_state = {m_state[1:0], 1'b1};
        tick();
        scan_en = 1'b0;
        tick();
        check_eq("defer_scan_ps", {29'd0, ps_o}, {29'd0, m_state});

        // reset during EVAL
        in_valid = 1'b1; in_vec = 4'hB;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_cnt",   {16'd0, step_cnt},  32'd0);
        check_eq("mid_rst_pi",    {28'd0, pi_o},      32'd0);
        check_eq("mid_rst_ps",    {29'd0, ps_o},      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1; in_vec = 4'h0;
        #1 check_eq("post_rst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_eq("post_rst_eval_ps", {29'd0, ps_o}, 32'd0);
        tick();
        tick();

        // counter saturation on the narrow instance
        sat_in_valid = 1'b1;
        repeat (4) tick();
        check_eq("sat_cnt_2", {30'd0, sat_cnt}, 32'd2);
        repeat (8) tick();
        check_eq("sat_cnt_max", {30'd0, sat_cnt}, 32'd3);
        sat_in_valid = 1'b0;

        check_eq("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
